// File: rtl/pc_redirect_unit.sv
// PC register with sequential/branch/jump/register targets, stall-time redirect capture and IF/ID flush.
// Optional redirect statistics counters are enabled by defining PC_REDIRECT_STATS_EN.
//   state  | meaning
//   S_RUN  | normal fetch; redirects applied immediately unless stalled
//   S_PEND | a redirect captured under stall waits for the stall to clear
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  PCSel,
  input  logic [31:0] BranchBase,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] RegTarget,
  input  logic        Stall,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        RedirectPending
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0] RedirectCount,
  output logic [15:0] StallRedirectCount
`endif
);

  typedef enum logic {S_RUN = 1'b0, S_PEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        flush_q, flush_d;
  logic [31:0] pc_plus4;
  logic [31:0] sel_target;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = (PCSel != 2'd0);

  always_comb begin
    sel_target = pc_plus4;
    case (PCSel)
      2'd1:    sel_target = BranchBase + (BranchOffset << 2);
      2'd2:    sel_target = {BranchBase[31:28], JumpIndex, 2'b00};
      2'd3:    sel_target = RegTarget & 32'hFFFF_FFFC;
      default: sel_target = pc_plus4;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (Stall && redirect) state_d = S_PEND;
      S_PEND:  if (!Stall) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!Stall) begin
          pc_d    = sel_target;
          flush_d = redirect;
        end else if (redirect) begin
          pend_d = sel_target;
        end
      end
      S_PEND: begin
        // Inputs are ignored here; only the stall release matters.
        if (!Stall) begin
          pc_d    = pend_q;
          flush_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PC              = pc_q;
  assign PCPlus4         = pc_plus4;
  assign Flush           = flush_q;
  assign RedirectPending = (state_q == S_PEND);

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redir_cnt_d = redir_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_d) redir_cnt_d = redir_cnt_q + 32'd1;
    if ((state_q == S_RUN) && (state_d == S_PEND) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      redir_cnt_q <= 32'h0;
      stall_cnt_q <= 16'h0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign RedirectCount      = redir_cnt_q;
  assign StallRedirectCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed table-driven bench for pc_redirect_unit, plus a short redirect/statistics sequence.
module tb_pc_redirect_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  PCSel;
  logic [31:0] BranchBase;
  logic [31:0] BranchOffset;
  logic [25:0] JumpIndex;
  logic [31:0] RegTarget;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        RedirectPending;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] RedirectCount;
  logic [15:0] StallRedirectCount;
`endif

  always #5 Clk = ~Clk;

  pc_redirect_unit #(.RESET_PC(32'h0000_0040)) dut (
    .Clk(Clk), .Rst(Rst), .PCSel(PCSel), .BranchBase(BranchBase),
    .BranchOffset(BranchOffset), .JumpIndex(JumpIndex), .RegTarget(RegTarget),
    .Stall(Stall), .PC(PC), .PCPlus4(PCPlus4), .Flush(Flush),
    .RedirectPending(RedirectPending)
`ifdef PC_REDIRECT_STATS_EN
    , .RedirectCount(RedirectCount), .StallRedirectCount(StallRedirectCount)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] base;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] rtgt;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic add(input logic rst, input logic stall, input logic [1:0] sel,
                     input logic [31:0] base, input logic [31:0] off,
                     input logic [25:0] idx, input logic [31:0] rtgt,
                     input logic [31:0] epc, input logic ef, input logic ep);
    vec_t v;
    v.rst = rst; v.stall = stall; v.sel = sel; v.base = base; v.off = off;
    v.idx = idx; v.rtgt = rtgt; v.exp_pc = epc; v.exp_flush = ef; v.exp_pend = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic [1:0] sel,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [25:0] idx, input logic [31:0] rtgt);
    @(negedge Clk);
    Rst = rst; Stall = stall; PCSel = sel; BranchBase = base;
    BranchOffset = off; JumpIndex = idx; RegTarget = rtgt;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Rst = 1'b1; Stall = 1'b0; PCSel = 2'd0; BranchBase = '0;
    BranchOffset = '0; JumpIndex = '0; RegTarget = '0;

    //   rst stall sel base           off            idx         reg            exp_pc         fl pend
    add(1, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0040, 0, 0);
    add(0, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0044, 0, 0);
    add(0, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0048, 0, 0);
    add(0, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_004C, 0, 0);
    add(0, 0, 3, 32'h0,          32'h0,          26'h0,  32'h0000_0100,  32'h0000_0100, 1, 0);
    add(0, 0, 1, 32'h0000_0104,  32'hFFFF_FFFE,  26'h0,  32'h0,          32'h0000_00FC, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0100, 0, 0);
    add(0, 0, 2, 32'hA000_0008,  32'h0,          26'h10, 32'h0,          32'hA000_0040, 1, 0);
    add(0, 0, 3, 32'h0,          32'h0,          26'h0,  32'h0000_1237,  32'h0000_1234, 1, 0);
    add(0, 1, 1, 32'h0000_0100,  32'h0000_0040,  26'h0,  32'h0,          32'h0000_1234, 0, 1);
    add(0, 1, 2, 32'hB000_0000,  32'h0,          26'h3F, 32'h0,          32'h0000_1234, 0, 1);
    add(0, 1, 2, 32'hB000_0000,  32'h0,          26'h3F, 32'h0,          32'h0000_1234, 0, 1);
    add(0, 0, 2, 32'hB000_0000,  32'h0,          26'h3F, 32'h0,          32'h0000_0200, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0204, 0, 0);
    add(0, 1, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0204, 0, 0);
    add(0, 0, 3, 32'h0,          32'h0,          26'h0,  32'hFFFF_FFFF,  32'hFFFF_FFFC, 1, 0);
    add(0, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0000, 0, 0);
    add(0, 1, 1, 32'h0,          32'h0000_0001,  26'h0,  32'h0,          32'h0000_0000, 0, 1);
    add(1, 1, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0040, 0, 0);
    add(0, 0, 0, 32'h0,          32'h0,          26'h0,  32'h0,          32'h0000_0044, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].sel, vecs[i].base,
            vecs[i].off, vecs[i].idx, vecs[i].rtgt);
      chk($sformatf("v%0d pc", i), PC, vecs[i].exp_pc);
      chk($sformatf("v%0d pcplus4", i), PCPlus4, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d flush", i), {31'h0, Flush}, {31'h0, vecs[i].exp_flush});
      chk($sformatf("v%0d pending", i), {31'h0, RedirectPending}, {31'h0, vecs[i].exp_pend});
    end

    // Two direct redirects then one stalled redirect, all after the last reset.
    drive(0, 0, 1, 32'h0000_1000, 32'h0000_0004, 26'h0, 32'h0);
    chk("seq branch pc", PC, 32'h0000_1010);
    drive(0, 0, 2, 32'h0000_1000, 32'h0, 26'h100, 32'h0);
    chk("seq jump pc", PC, 32'h0000_0400);
    chk("seq jump flush", {31'h0, Flush}, 32'h1);
    drive(0, 1, 3, 32'h0, 32'h0, 26'h0, 32'h0000_0808);
    chk("seq capture pc", PC, 32'h0000_0400);
    chk("seq capture flush", {31'h0, Flush}, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0);
    chk("seq replay pc", PC, 32'h0000_0808);
    chk("seq replay flush", {31'h0, Flush}, 32'h1);
    drive(0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0);
    chk("seq after flush", {31'h0, Flush}, 32'h0);
    chk("seq after pc", PC, 32'h0000_080C);
`ifdef PC_REDIRECT_STATS_EN
    chk("redirect count", RedirectCount, 32'd3);
    chk("stall redirect count", {16'h0, StallRedirectCount}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumes the 2-bit PC-source select from the branch/jump select logic and owns the program counter register.
- Computes sequential, branch, jump and register targets and updates PC each cycle.
- Absorbs a redirect that arrives during a pipeline stall and replays it when the stall clears.
- Emits a one-cycle IF/ID flush on every applied redirect.
- Sits between the ID-stage select logic and the instruction memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- PCSel  input  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = register target.
- BranchBase  input  32  PC+4 of the ID-stage instruction; base for branch and jump targets.
- BranchOffset  input  32  sign-extended word offset; shifted left 2 internally.
- JumpIndex  input  26  J-type instruction index.
- RegTarget  input  32  jr source register value.
- Stall  input  1  hazard-unit stall; PC must hold while high.
- PC  output  32  current fetch address (registered).
- PCPlus4  output  32  PC+4, combinational from PC.
- Flush  output  1  registered one-cycle pulse; kills the IF/ID instruction.
- RedirectPending  output  1  high while a captured redirect waits in PEND.

Behaviour:
- Reset (Rst high at a rising edge):
  - PC <= RESET_PC, Flush <= 0, state <= RUN, pending target <= 0, RedirectPending <= 0.
  - Reset overrides everything, including a pending redirect, which is discarded.
- Target arithmetic, all mod 2^32 with no overflow flag:
  - PCPlus4 = PC + 4; 32'hFFFF_FFFC wraps to 0.
  - Branch = BranchBase + (BranchOffset << 2); bits shifted out are dropped.
  - Jump = {BranchBase[31:28], JumpIndex, 2'b00}.
  - Register = {RegTarget[31:2], 2'b00}; low bits are silently forced to zero.
- Redirect means PCSel != 0. Select value 0 is always treated as sequential.
- State RUN:
  - Stall=0, PCSel=0: PC <= PC+4; Flush <= 0.
  - Stall=0, PCSel!=0: PC <= selected target; Flush <= 1 next cycle; stay in RUN.
  - Stall=1, PCSel=0: PC holds; Flush <= 0.
  - Stall=1, PCSel!=0: capture the selected target into the pending register; PC holds; Flush <= 0; go to PEND; RedirectPending <= 1.
- State PEND:
  - PCSel and all target inputs are ignored.
  - Stall=1: hold PC and the pending target.
  - Stall=0: PC <= pending target; Flush <= 1; RedirectPending <= 0; go to RUN.
- Latency:
  - PC reflects a redirect one cycle after the sampling edge.
  - Flush is high for exactly the cycle in which the new PC is first presented.
- Back-to-back redirects in RUN, each with Stall=0: each is applied, and Flush stays high on consecutive cycles.
- Targets are computed from inputs sampled at the same edge in which the redirect is accepted or captured.
- Rst and Stall both high: reset wins.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN.
- When defined:
  - Adds output RedirectCount, 32 bits, reset to 0.
  - Increments by 1 on each cycle Flush goes high; wraps 32'hFFFF_FFFF to 0.
  - Adds output StallRedirectCount, 16 bits, reset to 0, which increments on each RUN-to-PEND transition and saturates at 16'hFFFF.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, then 3 cycles of PCSel=0, Stall=0 -> PC = 40, 44, 48, 4C; Flush stays 0.
- PC=32'h0000_0100, BranchBase=32'h0000_0104, BranchOffset=32'hFFFF_FFFE, PCSel=1 -> next PC=32'h0000_00FC; Flush=1 for exactly one cycle.
- PCSel=2, BranchBase=32'hA000_0008, JumpIndex=26'h0000010 -> PC=32'hA000_0040. PCSel=3, RegTarget=32'h0000_1237 -> PC=32'h0000_1234.
- Stall=1 with PCSel=1 (target 32'h200), then 2 stalled cycles with PCSel=2, then Stall=0:
  - PC holds and RedirectPending=1 for 3 cycles.
  - Then PC=32'h200 and Flush=1; the later PCSel=2 is ignored.
- PC=32'hFFFF_FFFC, PCSel=0 -> PC=0. Rst asserted while in PEND -> PC=RESET_PC, RedirectPending=0, pending redirect not applied.
- With PC_REDIRECT_STATS_EN defined, run 2 direct redirects plus 1 stalled redirect -> RedirectCount=3, StallRedirectCount=1.
